// File: rtl/reaction_ctrl_if.sv
// Signal bundle between the reaction-time sequencer and its environment:
// the debounced button level in, LED / status / result path out.
interface reaction_ctrl_if;
   logic        btn;
   logic        led_go;
   logic        busy;
   logic [13:0] result_ms;
   logic        result_valid;
   logic        false_start;
   logic        timeout;

   // environment side: drives the button, observes the trial outcome
   modport master (
      output btn,
      input  led_go, busy, result_ms, result_valid, false_start, timeout
   );

   // sequencer side
   modport slave (
      input  btn,
      output led_go, busy, result_ms, result_valid, false_start, timeout
   );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-time trial sequencer: arm on a press, wait a pseudo-random delay,
// light GO, then measure press latency in whole ms. Flags false starts and
// no-response timeouts. All outputs are registered from the next-state view,
// so they change on the same edge as the state they describe.
module reaction_ctrl #(
   parameter int unsigned CLKSPDMHZ    = 100,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter int unsigned TIMEOUT_MS   = 9999
) (
   input  logic           clk,
   input  logic           reset,
   reaction_ctrl_if.slave rc
);

   localparam int unsigned PS_COUNT = CLKSPDMHZ * 1000;
   localparam int unsigned PS_W     = $clog2(PS_COUNT);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PS_COUNT - 1);
   localparam logic [13:0] MIN_D  = 14'(MIN_DELAY_MS);
   localparam logic [13:0] TO_LIM = 14'(TIMEOUT_MS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_GO    = 3'd2,
      S_DONE  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            btn_q;
   logic            press;
   logic [15:0]     lfsr;
   logic            lfsr_fb;
   logic [PS_W-1:0] prescaler;
   logic            ms_tick;
   logic [13:0]     ms_cnt;
   logic [13:0]     delay_ms;
   logic            entering;
   logic            hit_delay;
   logic            hit_timeout;
   logic            new_trial;
   logic            wait_fault;
   logic            go_press;
   logic            go_timeout;

   assign press       = rc.btn & ~btn_q;
   assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign ms_tick     = (prescaler == PS_LAST);
   assign entering    = (state_nxt != state);
   // ms_cnt+1 is formed one bit wider so the saturated count cannot wrap onto a match
   assign hit_delay   = (({1'b0, ms_cnt} + 15'd1) == {1'b0, delay_ms});
   assign hit_timeout = (({1'b0, ms_cnt} + 15'd1) == {1'b0, TO_LIM});

   // next-state decode; press is checked first so it wins over a same-cycle expiry
   always_comb begin
      state_nxt  = state;
      new_trial  = 1'b0;
      wait_fault = 1'b0;
      go_press   = 1'b0;
      go_timeout = 1'b0;
      case (state)
         S_IDLE: begin
            if (press) begin
               state_nxt = S_WAIT;
               new_trial = 1'b1;
            end
         end
         S_WAIT: begin
            if (press) begin
               state_nxt  = S_FAULT;
               wait_fault = 1'b1;
            end else if (ms_tick && hit_delay) begin
               state_nxt = S_GO;
            end
         end
         S_GO: begin
            if (press) begin
               state_nxt = S_DONE;
               go_press  = 1'b1;
            end else if (ms_tick && hit_timeout) begin
               state_nxt  = S_DONE;
               go_timeout = 1'b1;
            end
         end
         S_DONE, S_FAULT: begin
            if (press) begin
               state_nxt = S_WAIT;
               new_trial = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // button edge history and free-running LFSR (shifts in every state)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_q <= 1'b1;
         lfsr  <= 16'hACE1;
      end else begin
         btn_q <= rc.btn;
         lfsr  <= {lfsr[14:0], lfsr_fb};
      end
   end

   // ms time base: prescaler restarts on any state change, ms_cnt restarts on WAIT/GO entry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prescaler <= '0;
         ms_cnt    <= '0;
      end else begin
         if (entering || ms_tick) prescaler <= '0;
         else                     prescaler <= prescaler + PS_W'(1);

         if (entering && (state_nxt == S_WAIT || state_nxt == S_GO)) ms_cnt <= '0;
         else if (ms_tick && ms_cnt != '1)                            ms_cnt <= ms_cnt + 14'd1;
      end
   end

   // random wait length, captured from the LFSR at the arming press
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         delay_ms <= '0;
      else if (new_trial) delay_ms <= MIN_D + {3'b000, lfsr[10:0]};
   end

   // registered outputs: status follows next state, result path updates only on GO exit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rc.led_go       <= 1'b0;
         rc.busy         <= 1'b0;
         rc.result_ms    <= '0;
         rc.result_valid <= 1'b0;
         rc.false_start  <= 1'b0;
         rc.timeout      <= 1'b0;
      end else begin
         rc.led_go       <= (state_nxt == S_GO);
         rc.busy         <= (state_nxt == S_WAIT) || (state_nxt == S_GO);
         rc.result_valid <= go_press | go_timeout;

         if (go_press)        rc.result_ms <= ms_cnt;
         else if (go_timeout) rc.result_ms <= TO_LIM;

         if (new_trial)       rc.false_start <= 1'b0;
         else if (wait_fault) rc.false_start <= 1'b1;

         if (new_trial)       rc.timeout <= 1'b0;
         else if (go_timeout) rc.timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with 1 ms = 1000 clk, 4 ms minimum wait
// and a 20 ms GO limit. Arming presses are placed on cycles where the
// reference LFSR has small low bits so each random wait stays short.
module tb_reaction_ctrl;

   localparam int unsigned MS     = 1000;
   localparam int unsigned MIN_MS = 4;
   localparam int unsigned TO_MS  = 20;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   reaction_ctrl_if rif ();

   reaction_ctrl #(
      .CLKSPDMHZ    (1),
      .MIN_DELAY_MS (MIN_MS),
      .TIMEOUT_MS   (TO_MS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .rc    (rif)
   );

   always #5 clk = ~clk;

   // reference LFSR: x^16+x^14+x^13+x^11 Fibonacci, seed ACE1, one step per clk
   logic [15:0] m_lfsr;
   always @(posedge clk or negedge reset) begin
      if (!reset) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // press on a cycle whose LFSR low bits are 0 or 1; returns the expected wait in ms
   task automatic start_trial(output int unsigned d);
      bit found;
      found = 1'b0;
      d = MIN_MS;
      rif.btn = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 20000 && !found; i++) begin
         @(negedge clk);
         if (m_lfsr[10:0] <= 11'd1) begin
            d = MIN_MS + 32'(m_lfsr[10:0]);
            rif.btn = 1'b1;
            found = 1'b1;
         end
      end
      chk_val("lfsr_search", 32'(found), 1);
      @(posedge clk);
      #1;
      chk_val("arm_busy", rif.busy, 1);
      chk_val("arm_false_start", rif.false_start, 0);
      chk_val("arm_timeout", rif.timeout, 0);
      chk_val("arm_led_go", rif.led_go, 0);
      @(negedge clk);
      rif.btn = 1'b0;
   endtask

   // clocks until led_go is seen high, bounded
   task automatic wait_go(output int unsigned n);
      n = 0;
      while (n < 30000) begin
         @(posedge clk);
         #1;
         n++;
         if (rif.led_go) break;
      end
   endtask

   // clocks until result_valid is seen high, bounded
   task automatic wait_result(output int unsigned n);
      n = 0;
      while (n < 30000) begin
         @(posedge clk);
         #1;
         n++;
         if (rif.result_valid) break;
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got no finish, expected finish before 1500000 ns");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      int unsigned d;
      int unsigned n;
      int unsigned seen;
      rif.btn = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk_val("rst_led_go", rif.led_go, 0);
      chk_val("rst_busy", rif.busy, 0);
      chk_val("rst_result_ms", 32'(rif.result_ms), 0);
      chk_val("rst_result_valid", rif.result_valid, 0);
      chk_val("rst_false_start", rif.false_start, 0);
      chk_val("rst_timeout", rif.timeout, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk_val("idle_busy", rif.busy, 0);

      // 1: arm, GO after exactly delay_ms*1000 clk
      start_trial(d);
      wait_go(n);
      chk_val("go_delay_1", n, d * MS);
      chk_val("go_busy", rif.busy, 1);

      // 2: press 7.5 ms into GO
      repeat (7 * MS + MS / 2 - 1) @(posedge clk);
      @(negedge clk);
      rif.btn = 1'b1;
      @(posedge clk);
      #1;
      chk_val("press_valid", rif.result_valid, 1);
      chk_val("press_result", 32'(rif.result_ms), 7);
      chk_val("press_led_go", rif.led_go, 0);
      chk_val("press_timeout", rif.timeout, 0);
      chk_val("press_busy", rif.busy, 0);
      @(negedge clk);
      rif.btn = 1'b0;
      @(posedge clk);
      #1;
      chk_val("press_valid_pulse", rif.result_valid, 0);

      // 3: false start during WAIT
      start_trial(d);
      repeat (100) @(posedge clk);
      @(negedge clk);
      rif.btn = 1'b1;
      @(posedge clk);
      #1;
      chk_val("fs_flag", rif.false_start, 1);
      chk_val("fs_busy", rif.busy, 0);
      chk_val("fs_result_kept", 32'(rif.result_ms), 7);
      chk_val("fs_no_valid", rif.result_valid, 0);
      @(negedge clk);
      rif.btn = 1'b0;
      seen = 0;
      repeat (d * MS + 10) begin
         @(posedge clk);
         #1;
         if (rif.led_go || rif.busy || rif.result_valid) seen++;
      end
      chk_val("fs_no_go", seen, 0);
      chk_val("fs_sticky", rif.false_start, 1);
      start_trial(d);
      chk_val("retrial_result_kept", 32'(rif.result_ms), 7);

      // 4: no response -> timeout at 20 ms
      wait_go(n);
      chk_val("go_delay_2", n, d * MS);
      wait_result(n);
      chk_val("to_latency", n, TO_MS * MS);
      chk_val("to_result", 32'(rif.result_ms), TO_MS);
      chk_val("to_flag", rif.timeout, 1);
      chk_val("to_led_go", rif.led_go, 0);
      @(posedge clk);
      #1;
      chk_val("to_valid_pulse", rif.result_valid, 0);
      chk_val("to_sticky", rif.timeout, 1);

      // 5a: press on the exact WAIT-expiry clk
      start_trial(d);
      repeat (d * MS - 1) @(posedge clk);
      #1;
      chk_val("exp_pre_led_go", rif.led_go, 0);
      @(negedge clk);
      rif.btn = 1'b1;
      @(posedge clk);
      #1;
      chk_val("exp_false_start", rif.false_start, 1);
      chk_val("exp_led_go", rif.led_go, 0);
      chk_val("exp_busy", rif.busy, 0);
      @(negedge clk);
      rif.btn = 1'b0;

      // 5b: press on the exact timeout clk
      start_trial(d);
      wait_go(n);
      chk_val("go_delay_3", n, d * MS);
      repeat (TO_MS * MS - 1) @(posedge clk);
      @(negedge clk);
      rif.btn = 1'b1;
      @(posedge clk);
      #1;
      chk_val("edge_valid", rif.result_valid, 1);
      chk_val("edge_result", 32'(rif.result_ms), TO_MS - 1);
      chk_val("edge_timeout", rif.timeout, 0);
      chk_val("edge_led_go", rif.led_go, 0);
      @(negedge clk);
      rif.btn = 1'b0;

      // 6: asynchronous reset in the middle of GO, button held through release
      start_trial(d);
      wait_go(n);
      chk_val("go_delay_4", n, d * MS);
      repeat (50) @(posedge clk);
      #2;
      reset   = 1'b0;
      rif.btn = 1'b1;
      #1;
      chk_val("async_led_go", rif.led_go, 0);
      chk_val("async_busy", rif.busy, 0);
      chk_val("async_result_ms", 32'(rif.result_ms), 0);
      chk_val("async_valid", rif.result_valid, 0);
      chk_val("async_false_start", rif.false_start, 0);
      chk_val("async_timeout", rif.timeout, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk_val("held_busy", rif.busy, 0);
      chk_val("held_led_go", rif.led_go, 0);
      @(negedge clk);
      rif.btn = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk_val("release_busy", rif.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
